bus_initiator: RTL and testbench

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/global_constants_pkg.sv | 27 ++
 rtl/io_bus.sv | 21 ++
 rtl/bus_initiator.sv | 161 ++++++++++++++++
 tb/tb_bus_initiator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/global_constants_pkg.sv
// Shared system constants: register map, bus widths and the bus initiator FSM encoding.
package global_constants;

  localparam int unsigned REG_ADDR_W             = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000;

  localparam logic [REG_ADDR_W-1:0] PWM_BASE          = 8'h20;
  localparam int unsigned           NOS_PWM_REGISTERS = 4;

  localparam logic [REG_ADDR_W-1:0] PWM_PERIOD = 8'd0;
  localparam logic [REG_ADDR_W-1:0] PWM_DUTY   = 8'd1;
  localparam logic [REG_ADDR_W-1:0] PWM_CONFIG = 8'd2;
  localparam logic [REG_ADDR_W-1:0] PWM_COUNT  = 8'd3;

  localparam logic [31:0] T_PERIOD_ADJUSTMENT = 32'd2;

  typedef enum logic [2:0] {
    IDLE,
    DATA_REQ,
    DATA_ACK,
    STATUS_REQ,
    STATUS_ACK,
    DONE,
    TIMEOUT
  } bus_state_t;

endpackage

// File: rtl/io_bus.sv
// Internal 32-bit register bus with a two-wire four-phase handshake.
interface IO_bus;

  logic [global_constants::REG_ADDR_W-1:0] reg_address;
  logic [31:0]                             data_out;
  logic [31:0]                             data_in;
  logic                                    RW;
  logic                                    handshake_1;
  logic                                    handshake_2;

  modport initiator (
    output reg_address, data_out, RW, handshake_1,
    input  data_in, handshake_2
  );

  modport target (
    input  reg_address, data_out, RW, handshake_1,
    output data_in, handshake_2
  );

endinterface

// File: rtl/bus_initiator.sv
// Bus initiator: turns a cmd_valid/cmd_ready command into a data phase plus a status
// phase on IO_bus, each a full four-phase handshake guarded by a per-edge timeout.
module bus_initiator
  import global_constants::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_RW,
  input  logic [REG_ADDR_W-1:0] cmd_reg_address,
  input  logic [31:0]           cmd_data,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [31:0]           rsp_status,
  output logic                  rsp_timeout,
  IO_bus.initiator              bus
);

  localparam int unsigned      CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  seen_low_q, seen_low_d;
  logic                  hs1_q, hs1_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rw_q, rw_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic [31:0]           status_cap_q, status_cap_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [31:0]           rsp_status_q, rsp_status_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  waiting;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      seen_low_q    <= 1'b0;
      hs1_q         <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_data_q     <= '0;
      status_cap_q  <= '0;
      rsp_data_q    <= '0;
      rsp_status_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seen_low_q    <= seen_low_d;
      hs1_q         <= hs1_d;
      cmd_ready_q   <= cmd_ready_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_data_q     <= rd_data_d;
      status_cap_q  <= status_cap_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    seen_low_d    = seen_low_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_data_d     = rd_data_q;
    status_cap_d  = status_cap_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    rsp_timeout_d = rsp_timeout_q;
    waiting       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d    = DATA_REQ;
          rw_d       = cmd_RW;
          addr_d     = cmd_reg_address;
          wdata_d    = cmd_data;
          // The sample taken on the accepting edge is the first look at handshake_2 in DATA_REQ.
          seen_low_d = !bus.handshake_2;
        end
      end
      DATA_REQ: begin
        waiting = 1'b1;
        if (bus.handshake_2 && seen_low_q) begin
          state_d = DATA_ACK;
          if (!rw_q) rd_data_d = bus.data_in;
        end else if (!bus.handshake_2) begin
          seen_low_d = 1'b1;
        end
      end
      DATA_ACK: begin
        waiting = 1'b1;
        if (!bus.handshake_2) state_d = STATUS_REQ;
      end
      STATUS_REQ: begin
        waiting = 1'b1;
        if (bus.handshake_2) begin
          state_d      = STATUS_ACK;
          status_cap_d = bus.data_in;
        end
      end
      STATUS_ACK: begin
        waiting = 1'b1;
        if (!bus.handshake_2) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      TIMEOUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Expiry only wins when the awaited level did not arrive in the same cycle.
    if (waiting && (state_d == state_q) && (cnt_q == '0)) state_d = TIMEOUT;

    if ((state_d != state_q) &&
        (state_d inside {DATA_REQ, DATA_ACK, STATUS_REQ, STATUS_ACK})) begin
      cnt_d = CNT_RELOAD;
    end else if (waiting && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (state_d == DONE) begin
      rsp_data_d    = rw_q ? '0 : rd_data_q;
      rsp_status_d  = status_cap_q;
      rsp_timeout_d = 1'b0;
    end else if (state_d == TIMEOUT) begin
      rsp_data_d    = '0;
      rsp_status_d  = '1;
      rsp_timeout_d = 1'b1;
    end

    hs1_d       = (state_d == DATA_REQ) || (state_d == STATUS_REQ);
    cmd_ready_d = (state_d == IDLE);
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = (state_q == DONE) || (state_q == TIMEOUT);
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_timeout = rsp_timeout_q;

  assign bus.reg_address = addr_q;
  assign bus.data_out    = wdata_q;
  assign bus.RW          = rw_q;
  assign bus.handshake_1 = hs1_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: a PWM-channel responder on IO_bus plus a register-map
// reference model that predicts every response.
module tb_bus_initiator;
  import global_constants::*;

  localparam int unsigned TO_CYCLES = 16;
  localparam logic [31:0] STATUS_OK = 32'h0000_0001;

  logic        clk             = 1'b0;
  logic        reset           = 1'b0;
  logic        cmd_valid       = 1'b0;
  logic        cmd_ready;
  logic        cmd_RW          = 1'b0;
  logic [7:0]  cmd_reg_address = '0;
  logic [31:0] cmd_data        = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] rsp_status;
  logic        rsp_timeout;

  IO_bus bus_if ();

  bus_initiator #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_RW          (cmd_RW),
    .cmd_reg_address (cmd_reg_address),
    .cmd_data        (cmd_data),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_status      (rsp_status),
    .rsp_timeout     (rsp_timeout),
    .bus             (bus_if)
  );

  always #10 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit mapped(input logic [7:0] a);
    return (32'(a) >= 32'(PWM_BASE)) && (32'(a) < 32'(PWM_BASE) + NOS_PWM_REGISTERS);
  endfunction

  // Responder: a PWM channel reacting on the falling clock edge after a programmable delay.
  logic [31:0] pregs    [NOS_PWM_REGISTERS];
  logic [31:0] ref_regs [NOS_PWM_REGISTERS];
  int unsigned rsp_phase    = 0;
  int unsigned rsp_wait     = 0;
  int unsigned max_dly      = 0;
  bit          stall_status = 1'b0;
  int unsigned p_off;

  always @(negedge clk) begin
    if (!reset) begin
      rsp_phase              = 0;
      rsp_wait               = 0;
      bus_if.handshake_2     = 1'b0;
      bus_if.data_in         = '0;
    end else if (rsp_wait != 0) begin
      rsp_wait--;
    end else begin
      case (rsp_phase)
        0: if (bus_if.handshake_1 && mapped(bus_if.reg_address)) begin
             p_off = 32'(bus_if.reg_address - PWM_BASE);
             if (bus_if.RW) begin
               pregs[p_off]   = (p_off == 32'(PWM_PERIOD)) ? bus_if.data_out - T_PERIOD_ADJUSTMENT
                                                           : bus_if.data_out;
               bus_if.data_in = $urandom();
             end else begin
               bus_if.data_in = pregs[p_off];
             end
             bus_if.handshake_2 = 1'b1;
             rsp_phase          = 1;
             rsp_wait           = $urandom_range(max_dly, 0);
           end
        1: if (!bus_if.handshake_1) begin
             bus_if.handshake_2 = 1'b0;
             rsp_phase          = 2;
             rsp_wait           = $urandom_range(max_dly, 0);
           end
        2: if (bus_if.handshake_1 && !stall_status) begin
             bus_if.data_in     = STATUS_OK;
             bus_if.handshake_2 = 1'b1;
             rsp_phase          = 3;
             rsp_wait           = $urandom_range(max_dly, 0);
           end
        default: if (!bus_if.handshake_1) begin
             bus_if.handshake_2 = 1'b0;
             rsp_phase          = 0;
             rsp_wait           = $urandom_range(max_dly, 0);
           end
      endcase
    end
  end

  // Issues one command, predicts its response from the register map, checks it.
  // lat counts clk cycles with the accepting cycle as 1 and the rsp_valid cycle included.
  task automatic run_cmd(input string tag, input logic rw, input logic [7:0] a,
                         input logic [31:0] d, output int unsigned lat);
    logic [31:0] exp_data, exp_status;
    logic        exp_to;
    int unsigned off, n;
    if (!mapped(a)) begin
      exp_data   = '0;
      exp_status = '1;
      exp_to     = 1'b1;
    end else begin
      off        = 32'(a - PWM_BASE);
      exp_to     = 1'b0;
      exp_status = STATUS_OK;
      if (rw) begin
        ref_regs[off] = (off == 32'(PWM_PERIOD)) ? d - T_PERIOD_ADJUSTMENT : d;
        exp_data      = '0;
      end else begin
        exp_data = ref_regs[off];
      end
    end
    cmd_valid = 1'b1; cmd_RW = rw; cmd_reg_address = a; cmd_data = d;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check_eq({tag, "_accept"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_RW = ~rw; cmd_reg_address = ~a; cmd_data = ~d;
    check_eq({tag, "_bus_addr"}, 32'(bus_if.reg_address), 32'(a));
    check_eq({tag, "_bus_rw"}, 32'(bus_if.RW), 32'(rw));
    if (rw) check_eq({tag, "_bus_wdata"}, bus_if.data_out, d);
    lat = 2;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_data"}, rsp_data, exp_data);
    check_eq({tag, "_status"}, rsp_status, exp_status);
    check_eq({tag, "_timeout"}, 32'(rsp_timeout), 32'(exp_to));
    check_eq({tag, "_hs1_low"}, 32'(bus_if.handshake_1), 32'd0);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_hold_data"}, rsp_data, exp_data);
    check_eq({tag, "_hold_status"}, rsp_status, exp_status);
  endtask

  initial begin
    int unsigned lat, n, t, early, seen;
    logic [31:0] d1;
    logic [7:0]  a;
    logic        rw;

    for (int i = 0; i < int'(NOS_PWM_REGISTERS); i++) begin
      pregs[i]    = '0;
      ref_regs[i] = '0;
    end

    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_rsp_status", rsp_status, 32'd0);
    check_eq("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check_eq("rst_hs1", 32'(bus_if.handshake_1), 32'd0);
    check_eq("rst_bus_addr", 32'(bus_if.reg_address), 32'd0);
    check_eq("rst_bus_rw", 32'(bus_if.RW), 32'd0);
    check_eq("rst_bus_wdata", bus_if.data_out, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_ready_after_release", 32'(cmd_ready), 32'd1);

    max_dly = 0;
    run_cmd("wr_period", 1'b1, PWM_BASE + PWM_PERIOD, 32'd50000, lat);
    check_eq("min_latency", lat, 32'd6);
    run_cmd("rd_period", 1'b0, PWM_BASE + PWM_PERIOD, 32'd0, lat);
    check_eq("rd_period_value", rsp_data, 32'd50000 - T_PERIOD_ADJUSTMENT);
    run_cmd("wr_config", 1'b1, PWM_BASE + PWM_CONFIG, 32'h0000_0001, lat);
    run_cmd("rd_config", 1'b0, PWM_BASE + PWM_CONFIG, 32'h0, lat);
    check_eq("rd_config_status_lo", 32'(rsp_status[15:0]), 32'h0001);

    run_cmd("timeout", 1'b1, 8'hFF, 32'hDEAD_BEEF, lat);
    check_eq("timeout_latency", lat, 32'(TO_CYCLES + 2));

    // Back-to-back: cmd_valid stays high across two commands.
    max_dly = 2;
    d1 = $urandom();
    ref_regs[PWM_DUTY] = d1;
    cmd_valid = 1'b1; cmd_RW = 1'b1; cmd_reg_address = PWM_BASE + PWM_DUTY; cmd_data = d1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check_eq("b2b_first_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_RW = 1'b0; cmd_data = ~d1;
    t = 0; early = 0;
    while (!rsp_valid && t < 100) begin
      if (cmd_ready) early++;
      @(negedge clk); t++;
    end
    check_eq("b2b_first_valid", 32'(rsp_valid), 32'd1);
    check_eq("b2b_first_data", rsp_data, 32'd0);
    check_eq("b2b_ready_in_done", 32'(cmd_ready), 32'd0);
    check_eq("b2b_no_early_accept", early, 32'd0);
    @(negedge clk);
    check_eq("b2b_ready_after_rsp", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("b2b_second_taken", 32'(cmd_ready), 32'd0);
    t = 0;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    check_eq("b2b_second_valid", 32'(rsp_valid), 32'd1);
    check_eq("b2b_second_data", rsp_data, d1);
    check_eq("b2b_second_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge clk);

    // Reset while the status request is outstanding.
    max_dly = 0; stall_status = 1'b1;
    cmd_valid = 1'b1; cmd_RW = 1'b0; cmd_reg_address = PWM_BASE + PWM_CONFIG;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(rsp_phase == 2 && bus_if.handshake_1) && n < 100) begin @(negedge clk); n++; end
    check_eq("mid_status_req_reached", 32'(bus_if.handshake_1), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_hs1", 32'(bus_if.handshake_1), 32'd0);
    check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(cmd_ready), 32'd0);
    seen = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid) seen++; end
    reset = 1'b1; stall_status = 1'b0;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
    check_eq("mid_no_rsp", seen, 32'd0);
    run_cmd("after_rst", 1'b0, PWM_BASE + PWM_CONFIG, 32'h0, lat);

    for (int i = 0; i < 40; i++) begin
      max_dly = $urandom_range(4, 0);
      if ($urandom_range(7, 0) == 0) a = 8'hFF;
      else a = PWM_BASE + 8'($urandom_range(NOS_PWM_REGISTERS - 1, 0));
      rw = 1'($urandom_range(1, 0));
      run_cmd("rand", rw, a, $urandom(), lat);
      check_eq("rand_lat_min", 32'(lat >= 6), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
